// File: rtl/port_fifo.sv
// Per-port output queue for the packet switch.
// Registered read, no fall-through, sticky overflow on a dropped write.
module port_fifo #(
    parameter int W_WIDTH = 8,
    parameter int DEPTH   = 4,
    parameter int PORT_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W_WIDTH-1:0]         port_addr,
    input  logic [W_WIDTH-1:0]         data_in,
    input  logic                       rd_en,
    output logic [W_WIDTH-1:0]         data_out,
    output logic                       data_valid,
    output logic                       port_busy,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               hit;
    logic               wr_ok;
    logic               rd_ok;
    logic               drop;

    assign hit       = wr_en && (port_addr == W_WIDTH'(PORT_ID));
    assign port_busy = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    // A full queue drops the write even if a read frees a slot this cycle.
    assign wr_ok     = hit && !port_busy;
    assign drop      = hit && port_busy;
    assign rd_ok     = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_port_fifo.sv
// Directed vector bench for port_fifo (W_WIDTH=8, DEPTH=4, PORT_ID=0).
// Table rows are checked 1 time unit after each rising edge.
module tb_port_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] port_addr;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       port_busy;
    logic       empty;
    logic [2:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    port_fifo #(.W_WIDTH(8), .DEPTH(4), .PORT_ID(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .port_addr(port_addr),
        .data_in(data_in),
        .rd_en(rd_en),
        .data_out(data_out),
        .data_valid(data_valid),
        .port_busy(port_busy),
        .empty(empty),
        .level(level),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] din;
        logic       rd;
        logic       v;
        logic [7:0] dout;
        logic [2:0] lvl;
        logic       busy;
        logic       emp;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic w, input logic [7:0] a,
        input logic [7:0] d, input logic rd, input logic v,
        input logic [7:0] o, input logic [2:0] l,
        input logic b, input logic e, input logic f);
        vec_t t;
        t.rst_n = r; t.wr = w; t.addr = a; t.din = d; t.rd = rd;
        t.v = v; t.dout = o; t.lvl = l; t.busy = b; t.emp = e;
        t.ovf = f;
        return t;
    endfunction

    task automatic drive(input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic rd);
        rst_n = r; wr_en = w; port_addr = a; data_in = d; rd_en = rd;
        @(posedge clk);
        #1;
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [14:0] a;
        logic [14:0] e;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        port_addr = '0; data_in = '0;

        //        rst wr addr  din  rd  v  dout lvl b e o
        vecs.push_back(mk(0,0,8'h00,8'h00,0, 0,8'h00,0,0,1,0));
        // basic write/read
        vecs.push_back(mk(1,1,8'h00,8'h11,0, 0,8'h00,1,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'h22,0, 0,8'h00,2,0,0,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'h11,1,0,0,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'h22,0,0,1,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,0, 0,8'h22,0,0,1,0));
        // address filtering
        vecs.push_back(mk(1,1,8'h01,8'h55,0, 0,8'h22,0,0,1,0));
        // fill, overflow, full+read drops the write
        vecs.push_back(mk(1,1,8'h00,8'hA0,0, 0,8'h22,1,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hA1,0, 0,8'h22,2,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hA2,0, 0,8'h22,3,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hA3,0, 0,8'h22,4,1,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hA4,0, 0,8'h22,4,1,0,1));
        vecs.push_back(mk(1,1,8'h00,8'hA5,1, 1,8'hA0,3,0,0,1));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'hA1,2,0,0,1));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'hA2,1,0,0,1));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'hA3,0,0,1,1));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 0,8'hA3,0,0,1,1));
        vecs.push_back(mk(0,0,8'h00,8'h00,0, 0,8'h00,0,0,1,0));
        // simultaneous read and write
        vecs.push_back(mk(1,1,8'h00,8'h01,0, 0,8'h00,1,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'h02,0, 0,8'h00,2,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'h03,1, 1,8'h01,2,0,0,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'h02,1,0,0,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'h03,0,0,1,0));
        // no fall-through on write into empty
        vecs.push_back(mk(1,1,8'h00,8'h77,1, 0,8'h03,1,0,0,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'h77,0,0,1,0));
        // reset mid-operation, reset beats wr/rd
        vecs.push_back(mk(1,1,8'h00,8'hB0,0, 0,8'h77,1,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hB1,0, 0,8'h77,2,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hB2,0, 0,8'h77,3,0,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hB3,0, 0,8'h77,4,1,0,0));
        vecs.push_back(mk(1,1,8'h00,8'hB4,0, 0,8'h77,4,1,0,1));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 1,8'hB0,3,0,0,1));
        vecs.push_back(mk(0,1,8'h00,8'hC9,1, 0,8'h00,0,0,1,0));
        vecs.push_back(mk(1,0,8'h00,8'h00,1, 0,8'h00,0,0,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].wr, vecs[i].addr,
                  vecs[i].din, vecs[i].rd);
            a = {data_valid, data_out, level, port_busy, empty, overflow};
            e = {vecs[i].v, vecs[i].dout, vecs[i].lvl,
                 vecs[i].busy, vecs[i].emp, vecs[i].ovf};
            chk($sformatf("vec%0d", i), 32'(a), 32'(e));
        end

        // single push/pop across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 8'h00, 8'(8'hC0 + i), 1'b0);
            chk($sformatf("wrap_push%0d_lvl", i), 32'(level), 32'd1);
            chk($sformatf("wrap_push%0d_v", i), 32'(data_valid), 32'd0);
            drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
            chk($sformatf("wrap_pop%0d", i),
                32'({data_valid, data_out, level}),
                32'({1'b1, 8'(8'hC0 + i), 3'd0}));
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("empty_rd", 32'({data_valid, data_out, empty}),
            32'({1'b0, 8'hC9, 1'b1}));

        // full-queue wrap: pointers start at offset 2 after 10 pops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h00, 8'(8'hD0 + i), 1'b0);
        end
        chk("wrap_full", 32'({port_busy, level}), 32'({1'b1, 3'd4}));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
            chk($sformatf("wrap_drain%0d", i),
                32'({data_valid, data_out}),
                32'({1'b1, 8'(8'hD0 + i)}));
        end
        chk("wrap_end", 32'({empty, overflow}), 32'({1'b1, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
